universal_reg: RTL and testbench

UNIVERSAL_REG -- requirements
Module: universal_reg

---
 rtl/universal_reg.sv | 113 +++++++++++
 tb/tb_universal_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/universal_reg.sv
// Universal register: parallel load, shift left/right with serial inputs,
// rotate left/right and modulo-2^WIDTH up/down counting. All outputs come
// straight from flops, so no input reaches an output combinationally.
module universal_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             wrap
);

    // Operation encodings; all eight codes are meaningful.
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_CUP   = 3'b110;
    localparam logic [2:0] MODE_CDN   = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             wrap_q, wrap_d;

    // Shift left, new bit enters at the LSB.
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                     input logic            fill);
        return {v[WIDTH-2:0], fill};
    endfunction

    // Shift right, new bit enters at the MSB.
    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                      input logic            fill);
        return {fill, v[WIDTH-1:1]};
    endfunction

    // A counter step wraps when incrementing all-ones or decrementing zero.
    function automatic logic wraps_up(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    function automatic logic wraps_down(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    // Next-state selection; sout and wrap default low so they only pulse
    // on the cycle after the operation that produces them.
    always_comb begin
        q_d    = q_q;
        sout_d = 1'b0;
        wrap_d = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = d;
                MODE_SHL: begin
                    q_d    = shift_left(q_q, sin_l);
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = shift_right(q_q, sin_r);
                    sout_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d    = shift_left(q_q, q_q[WIDTH-1]);
                    sout_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d    = shift_right(q_q, q_q[0]);
                    sout_d = q_q[0];
                end
                MODE_CUP: begin
                    q_d    = q_q + ONE;
                    wrap_d = wraps_up(q_q);
                end
                MODE_CDN: begin
                    q_d    = q_q - ONE;
                    wrap_d = wraps_down(q_q);
                end
                default: q_d = q_q;
            endcase
        end
    end

    // State registers; reset overrides any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= RESET_VAL;
            sout_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_universal_reg.sv
// Bench for universal_reg: directed table vectors, hand sequences for the
// reset-value instance, then a randomised run against a reference model.
module tb_universal_reg;

    logic       clk = 1'b0;
    logic       reset, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q,  q2;
    logic       sout, sout2, wrap, wrap2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    universal_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout(sout), .wrap(wrap)
    );

    universal_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q2), .sout(sout2), .wrap(wrap2)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [7:0] eq;
        logic       es;
        logic       ew;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] eq;
        logic       es;
        logic       ew;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(string name, logic rst, logic e, logic [2:0] m,
                                logic [7:0] dd, logic sl, logic sr,
                                logic [7:0] eq, logic es, logic ew);
        vec_t v;
        v.name = name; v.rst = rst; v.en = e; v.mode = m; v.d = dd;
        v.sl = sl; v.sr = sr; v.eq = eq; v.es = es; v.ew = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, then compare one edge later.
    task automatic step(input vec_t v);
        exp_t e;
        reset = v.rst; en = v.en; mode = v.mode; d = v.d;
        sin_l = v.sl;  sin_r = v.sr;
        e.name = v.name; e.eq = v.eq; e.es = v.es; e.ew = v.ew;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: got empty expected entry", v.name);
        end else begin
            e = sb.pop_front();
            check({e.name, "_q"},    q,          e.eq);
            check({e.name, "_sout"}, {7'd0, sout}, {7'd0, e.es});
            check({e.name, "_wrap"}, {7'd0, wrap}, {7'd0, e.ew});
        end
    endtask

    // Reference behaviour of the 8-bit register.
    task automatic model(input logic rst, input logic e, input logic [2:0] m,
                         input logic [7:0] dd, input logic sl, input logic sr,
                         inout logic [7:0] mq, output logic es, output logic ew);
        es = 1'b0; ew = 1'b0;
        if (rst) mq = 8'h00;
        else if (e) begin
            unique case (m)
                3'd0: ;
                3'd1: mq = dd;
                3'd2: begin es = mq[7]; mq = {mq[6:0], sl}; end
                3'd3: begin es = mq[0]; mq = {sr, mq[7:1]}; end
                3'd4: begin es = mq[7]; mq = {mq[6:0], mq[7]}; end
                3'd5: begin es = mq[0]; mq = {mq[0], mq[7:1]}; end
                3'd6: begin ew = (mq == 8'hFF); mq = mq + 8'd1; end
                3'd7: begin ew = (mq == 8'h00); mq = mq - 8'd1; end
            endcase
        end
    endtask

    initial begin
        logic [7:0] mq;
        logic       es, ew;
        vec_t       v;

        reset = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        @(negedge clk);

        //           name          rst en mode  d     sl sr  q     so wr
        tbl.push_back(mk("reset",   1, 0, 3'd0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk("loadA5",  0, 1, 3'd1, 8'hA5, 1, 1, 8'hA5, 0, 0));
        tbl.push_back(mk("rstprio", 1, 1, 3'd1, 8'hFF, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk("load81",  0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0, 0));
        tbl.push_back(mk("shl1",    0, 1, 3'd2, 8'hFF, 1, 0, 8'h03, 1, 0));
        tbl.push_back(mk("shl0",    0, 1, 3'd2, 8'hFF, 0, 1, 8'h06, 0, 0));
        tbl.push_back(mk("load81b", 0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0, 0));
        tbl.push_back(mk("shr0",    0, 1, 3'd3, 8'hFF, 1, 0, 8'h40, 1, 0));
        tbl.push_back(mk("shr1",    0, 1, 3'd3, 8'h00, 0, 1, 8'hA0, 0, 0));
        tbl.push_back(mk("load01",  0, 1, 3'd1, 8'h01, 0, 0, 8'h01, 0, 0));
        tbl.push_back(mk("ror",     0, 1, 3'd5, 8'hFF, 0, 0, 8'h80, 1, 0));
        tbl.push_back(mk("rol",     0, 1, 3'd4, 8'h00, 0, 0, 8'h01, 1, 0));
        tbl.push_back(mk("disable", 0, 0, 3'd4, 8'hFF, 1, 1, 8'h01, 0, 0));
        tbl.push_back(mk("hold",    0, 1, 3'd0, 8'hFF, 1, 1, 8'h01, 0, 0));
        tbl.push_back(mk("loadFE",  0, 1, 3'd1, 8'hFE, 0, 0, 8'hFE, 0, 0));
        tbl.push_back(mk("cup1",    0, 1, 3'd6, 8'h00, 1, 1, 8'hFF, 0, 0));
        tbl.push_back(mk("cup2",    0, 1, 3'd6, 8'h00, 1, 1, 8'h00, 0, 1));
        tbl.push_back(mk("cup3",    0, 1, 3'd6, 8'h00, 1, 1, 8'h01, 0, 0));
        tbl.push_back(mk("load00",  0, 1, 3'd1, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk("cdn1",    0, 1, 3'd7, 8'h55, 1, 1, 8'hFF, 0, 1));
        tbl.push_back(mk("cdn2",    0, 1, 3'd7, 8'h55, 1, 1, 8'hFE, 0, 0));
        tbl.push_back(mk("load3C",  0, 1, 3'd1, 8'h3C, 0, 0, 8'h3C, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("en0cnt", 0, 0, 3'd6, 8'hFF, 1, 1, 8'h3C, 0, 0));
        tbl.push_back(mk("loadFF",  0, 1, 3'd1, 8'hFF, 0, 0, 8'hFF, 0, 0));
        tbl.push_back(mk("rstwrap", 1, 1, 3'd6, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk("postrst", 0, 1, 3'd6, 8'h00, 0, 0, 8'h01, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset value instance: reset lands mid-count.
        step(mk("r5a_rst", 1, 0, 3'd0, 8'h00, 0, 0, 8'h00, 0, 0));
        check("r5a_after_reset", q2, 8'h5A);
        step(mk("r5a_load", 0, 1, 3'd1, 8'h10, 0, 0, 8'h10, 0, 0));
        step(mk("r5a_cnt1", 0, 1, 3'd6, 8'h00, 0, 0, 8'h11, 0, 0));
        check("r5a_cnt1_q2", q2, 8'h11);
        step(mk("r5a_cnt2", 0, 1, 3'd6, 8'h00, 0, 0, 8'h12, 0, 0));
        step(mk("r5a_midrst", 1, 1, 3'd6, 8'h00, 0, 0, 8'h00, 0, 0));
        check("r5a_midrst_q2", q2, 8'h5A);
        check("r5a_midrst_wrap2", {7'd0, wrap2}, 8'h00);
        step(mk("r5a_resume", 0, 1, 3'd6, 8'h00, 0, 0, 8'h01, 0, 0));
        check("r5a_resume_q2", q2, 8'h5B);

        // Randomised run; first vector is a reset so the model starts aligned.
        mq = 8'h00;
        for (int i = 0; i < 400; i++) begin
            v.name = "rand";
            v.rst  = (i == 0) || ($urandom_range(0, 39) == 0);
            v.en   = ($urandom_range(0, 4) != 0);
            v.mode = 3'($urandom_range(0, 7));
            v.d    = 8'($urandom);
            v.sl   = 1'($urandom);
            v.sr   = 1'($urandom);
            model(v.rst, v.en, v.mode, v.d, v.sl, v.sr, mq, es, ew);
            v.eq = mq; v.es = es; v.ew = ew;
            step(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
